// File: rtl/alu_wb_if.sv
// Execute->writeback handshake bundle: upstream ALU beat (in_*) and writeback port (out_*/wb_*).
// slave = the stage itself, master = the surrounding pipeline driving/consuming it.
interface alu_wb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic              in_neg;
    logic              in_upd_flag;
    logic [ADDR_W-1:0] in_rd;
    logic              in_wr_en;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] wb_rd;
    logic              wb_en;

    modport slave (
        input  in_valid, in_result, in_zero, in_neg, in_upd_flag, in_rd, in_wr_en, out_ready,
        output in_ready, out_valid, wb_data, wb_rd, wb_en
    );

    modport master (
        output in_valid, in_result, in_zero, in_neg, in_upd_flag, in_rd, in_wr_en, out_ready,
        input  in_ready, out_valid, wb_data, wb_rd, wb_en
    );
endinterface

// File: rtl/alu_wb_stage.sv
// ALU->writeback stage: 2-entry skid buffer (head drives writeback) plus the architectural Z/N flags.
// Optional macro ALU_WB_FWD_EN adds fwd_valid/fwd_rd/fwd_data operand-forwarding outputs.
module alu_wb_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    alu_wb_if.slave           bus,
`ifdef ALU_WB_FWD_EN
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              flag_z,
    output logic              flag_n
);
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] rd;
        logic              wr_en;
    } entry_t;

    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    logic   head_vld_q, head_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   in_ready_q, in_ready_d;
    logic   flag_z_q, flag_z_d;
    logic   flag_n_q, flag_n_d;

    entry_t in_beat;
    logic   accept;
    logic   drain;

    assign in_beat.data  = bus.in_result;
    assign in_beat.rd    = bus.in_rd;
    assign in_beat.wr_en = bus.in_wr_en;

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = head_vld_q & bus.out_ready;

    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        flag_z_d   = flag_z_q;
        flag_n_d   = flag_n_q;

        if (flush) begin
            head_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            // Flags commit at accept so the branch unit sees them one cycle later.
            if (accept && bus.in_upd_flag) begin
                flag_z_d = bus.in_zero;
                flag_n_d = bus.in_neg;
            end

            if (!head_vld_q || drain) begin
                if (skid_vld_q) begin
                    // in_ready was low, so no accept can collide with this refill.
                    head_d     = skid_q;
                    head_vld_d = 1'b1;
                    skid_vld_d = 1'b0;
                end else begin
                    if (accept) head_d = in_beat;
                    head_vld_d = accept;
                end
            end else if (accept) begin
                skid_d     = in_beat;
                skid_vld_d = 1'b1;
            end
        end

        in_ready_d = !skid_vld_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            flag_z_q   <= 1'b0;
            flag_n_q   <= 1'b0;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            flag_z_q   <= flag_z_d;
            flag_n_q   <= flag_n_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = head_vld_q;
    assign bus.wb_data   = head_q.data;
    assign bus.wb_rd     = head_q.rd;
    assign bus.wb_en     = head_vld_q & bus.out_ready & head_q.wr_en;
    assign flag_z        = flag_z_q;
    assign flag_n        = flag_n_q;

`ifdef ALU_WB_FWD_EN
    // Skid holds the younger beat, so it takes priority for forwarding.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        if (skid_vld_q && skid_q.wr_en) begin
            fwd_valid = 1'b1;
            fwd_rd    = skid_q.rd;
            fwd_data  = skid_q.data;
        end else if (head_vld_q && head_q.wr_en) begin
            fwd_valid = 1'b1;
            fwd_rd    = head_q.rd;
            fwd_data  = head_q.data;
        end
    end
`endif
endmodule
